sha256_digest_collector: RTL

//  Sits directly downstream of the SHA-256 core. Gathers the core's 26-beat, 10-bit digest stream
//  (260 bits, MSB-first, 4 trailing zero pad bits) into one 256-bit digest. Presents the digest on a

---
 rtl/sha256_pkg.sv | 26 ++
 rtl/sha256_beat_packer.sv | 80 ++++++++
 rtl/sha256_digest_collector.sv | 104 ++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 digest collector.
// ASM_W is the full beat stream width: 256 digest bits plus a 4-bit zero pad.
package sha256_pkg;

  localparam int BEAT_W    = 10;
  localparam int DIGEST_W  = 256;
  localparam int GAP_MAX   = 4;
  localparam int NUM_BEATS = 26;
  localparam int PAD_BITS  = 4;
  localparam int ASM_W     = NUM_BEATS * BEAT_W;
  localparam int CNT_W     = 5;
  localparam int GAP_W     = 3;

  typedef logic [DIGEST_W-1:0] digest_t;
  typedef logic [ASM_W-1:0]    asm_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

  function automatic logic pad_nonzero(input asm_t w);
    return |w[PAD_BITS-1:0];
  endfunction

endpackage

// File: rtl/sha256_beat_packer.sv
// Shifts 26 MSB-first beats into a 260-bit word; done_o/abort_o are combinational
// pulses in the cycle of the completing beat or the gap-timeout idle cycle.
module sha256_beat_packer
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              beat_vld_i,
  output logic              done_o,
  output logic [ASM_W-1:0]  word_o,
  output logic              abort_o
);

  asm_state_t       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  asm_t             asm_q, asm_d;
  asm_t             shifted;

  assign shifted = {asm_q[ASM_W-BEAT_W-1:0], beat_i};
  assign word_o  = shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    asm_d      = asm_q;
    done_o     = 1'b0;
    abort_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat_vld_i) begin
          asm_d      = shifted;
          beat_cnt_d = CNT_W'(1);
          gap_cnt_d  = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (beat_vld_i) begin
          asm_d     = shifted;
          gap_cnt_d = '0;
          if (beat_cnt_q == CNT_W'(NUM_BEATS - 1)) begin
            done_o     = 1'b1;
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else if (gap_cnt_q == GAP_W'(GAP_MAX - 1)) begin
          // This idle cycle brings the gap count to GAP_MAX: drop the partial frame.
          abort_o    = 1'b1;
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
          asm_d      = '0;
          state_d    = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/sha256_digest_collector.sv
// Collects the SHA-256 core's beat stream into a 256-bit digest slot with sticky fault flags.
// Optional DIGEST_COMPARE_EN adds expected_digest input and registered digest_match output.
module sha256_digest_collector
  import sha256_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BEAT_W-1:0]   hash_in,
  input  logic                hash_valid,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic                frame_err,
  output logic                pad_err,
  output logic                overflow_err,
  input  logic                err_clr
`ifdef DIGEST_COMPARE_EN
  ,
  input  logic [DIGEST_W-1:0] expected_digest,
  output logic                digest_match
`endif
);

  logic       done, abort;
  asm_t       word;
  digest_t    new_digest;
  logic       handshake, load;
  logic       overflow_set, pad_set;

  digest_t    digest_q, digest_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       pad_err_q, pad_err_d;
  logic       overflow_err_q, overflow_err_d;

  sha256_beat_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_i     (hash_in),
    .beat_vld_i (hash_valid),
    .done_o     (done),
    .word_o     (word),
    .abort_o    (abort)
  );

  assign new_digest   = word[ASM_W-1:PAD_BITS];
  assign handshake    = valid_q & digest_ready;
  // A completing frame only enters the slot if it is empty or draining this cycle.
  assign load         = done & (~valid_q | handshake);
  assign overflow_set = done & valid_q & ~digest_ready;
  assign pad_set      = done & pad_nonzero(word);

  always_comb begin
    digest_d = digest_q;
    valid_d  = valid_q;
    if (handshake) valid_d = 1'b0;
    if (load) begin
      digest_d = new_digest;
      valid_d  = 1'b1;
    end
    frame_err_d    = (frame_err_q    & ~err_clr) | abort;
    pad_err_d      = (pad_err_q      & ~err_clr) | pad_set;
    overflow_err_d = (overflow_err_q & ~err_clr) | overflow_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest_q       <= '0;
      valid_q        <= 1'b0;
      frame_err_q    <= 1'b0;
      pad_err_q      <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      digest_q       <= digest_d;
      valid_q        <= valid_d;
      frame_err_q    <= frame_err_d;
      pad_err_q      <= pad_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  assign digest       = digest_q;
  assign digest_valid = valid_q;
  assign frame_err    = frame_err_q;
  assign pad_err      = pad_err_q;
  assign overflow_err = overflow_err_q;

`ifdef DIGEST_COMPARE_EN
  logic match_q, match_d;

  always_comb begin
    match_d = match_q;
    if (load) match_d = (new_digest == expected_digest);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_q <= 1'b0;
    else        match_q <= match_d;
  end

  assign digest_match = match_q;
`endif

endmodule
